// File: rtl/cdec_pkg.sv
// ---------------------------------------------------------------------------
// cdec_pkg
// Shared encodings for the CDEC 8-bit CPU sequencer: sequencer states,
// opcodes, Xbus source/destination codes, ALU operations, and helpers that
// map instruction fields onto bus and ALU codes.
// ---------------------------------------------------------------------------
package cdec_pkg;

   // Sequencer states. The numeric values are visible on dbg_state.
   typedef enum logic [3:0] {
      ST_F0   = 4'd0,
      ST_F1   = 4'd1,
      ST_F2   = 4'd2,
      ST_F3   = 4'd3,
      ST_E0   = 4'd4,
      ST_E1   = 4'd5,
      ST_E2   = 4'd6,
      ST_E3   = 4'd7,
      ST_HALT = 4'd8
   } state_t;

   // Opcodes held in I[7:4]
   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_MOV  = 4'h1;
   localparam logic [3:0] OP_LDI  = 4'h2;
   localparam logic [3:0] OP_LD   = 4'h3;
   localparam logic [3:0] OP_ST   = 4'h4;
   localparam logic [3:0] OP_ADD  = 4'h5;
   localparam logic [3:0] OP_SUB  = 4'h6;
   localparam logic [3:0] OP_AND  = 4'h7;
   localparam logic [3:0] OP_OR   = 4'h8;
   localparam logic [3:0] OP_XOR  = 4'h9;
   localparam logic [3:0] OP_JMP  = 4'hA;
   localparam logic [3:0] OP_JZ   = 4'hB;
   localparam logic [3:0] OP_JC   = 4'hC;
   localparam logic [3:0] OP_JS   = 4'hD;
   localparam logic [3:0] OP_HALT = 4'hF;

   // Xbus sources
   localparam logic [2:0] SRC_PC  = 3'd0;
   localparam logic [2:0] SRC_A   = 3'd1;
   localparam logic [2:0] SRC_B   = 3'd2;
   localparam logic [2:0] SRC_C   = 3'd3;
   localparam logic [2:0] SRC_R   = 3'd4;
   localparam logic [2:0] SRC_RD  = 3'd5;
   localparam logic [2:0] SRC_FLG = 3'd6;
   localparam logic [2:0] SRC_FF  = 3'd7;

   // Xbus destinations
   localparam logic [2:0] DST_PC  = 3'd0;
   localparam logic [2:0] DST_A   = 3'd1;
   localparam logic [2:0] DST_B   = 3'd2;
   localparam logic [2:0] DST_C   = 3'd3;
   localparam logic [2:0] DST_MAR = 3'd4;
   localparam logic [2:0] DST_WDR = 3'd5;
   localparam logic [2:0] DST_T   = 3'd6;
   localparam logic [2:0] DST_I   = 3'd7;

   // ALU operations
   localparam logic [3:0] ALU_PASS = 4'd0;
   localparam logic [3:0] ALU_INC  = 4'd1;
   localparam logic [3:0] ALU_ADD  = 4'd2;
   localparam logic [3:0] ALU_SUB  = 4'd3;
   localparam logic [3:0] ALU_AND  = 4'd4;
   localparam logic [3:0] ALU_OR   = 4'd5;
   localparam logic [3:0] ALU_XOR  = 4'd6;

   // Register field (0 A, 1 B, 2 C, 3 PC) to Xbus code. Source and
   // destination codes coincide for A/B/C/PC, so one mapping serves both.
   function automatic logic [2:0] regToBus(input logic [1:0] r);
      return (r == 2'd3) ? 3'd0 : ({1'b0, r} + 3'd1);
   endfunction

   // Two-operand opcode to ALU operation; anything else passes through.
   function automatic logic [3:0] aluForOp(input logic [3:0] op);
      case (op)
         OP_ADD:  return ALU_ADD;
         OP_SUB:  return ALU_SUB;
         OP_AND:  return ALU_AND;
         OP_OR:   return ALU_OR;
         OP_XOR:  return ALU_XOR;
         default: return ALU_PASS;
      endcase
   endfunction

endpackage

// File: rtl/cdec_decode.sv
// ---------------------------------------------------------------------------
// cdec_decode
// Combinational microcode: for the current sequencer step, the instruction
// and the flags, produce the single Xbus transfer of the cycle.
// Ports:
//   i_state     current sequencer state
//   i_instr     instruction register {opcode, rd, rs}
//   i_szcy      flags {S,Z,Cy}
//   o_xsrc      Xbus source code
//   o_xdst      Xbus destination code
//   o_aluop     ALU operation
//   o_rwe       1 = real transfer this cycle
//   o_flgwe     load flags from the ALU
//   o_memWe     memory write strobe
//   o_lastStep  1 = this execute step finishes the instruction
// ---------------------------------------------------------------------------
module cdec_decode
   import cdec_pkg::*;
(
   input  state_t      i_state,
   input  logic [7:0]  i_instr,
   input  logic [2:0]  i_szcy,
   output logic [2:0]  o_xsrc,
   output logic [2:0]  o_xdst,
   output logic [3:0]  o_aluop,
   output logic        o_rwe,
   output logic        o_flgwe,
   output logic        o_memWe,
   output logic        o_lastStep
);

   logic [3:0] w_op;
   logic [2:0] w_rdBus;
   logic [2:0] w_rsBus;
   logic       w_isAlu;
   logic       w_isImm;
   logic       w_taken;

   assign w_op    = i_instr[7:4];
   assign w_rdBus = regToBus(i_instr[3:2]);
   assign w_rsBus = regToBus(i_instr[1:0]);
   assign w_isAlu = (w_op >= OP_ADD) && (w_op <= OP_XOR);
   // LDI and all jumps share the immediate-fetch steps E0..E2
   assign w_isImm = (w_op == OP_LDI) || ((w_op >= OP_JMP) && (w_op <= OP_JS));

   // Jump condition, evaluated on the flags present during E3
   always_comb begin
      w_taken = 1'b0;
      case (w_op)
         OP_JMP:  w_taken = 1'b1;
         OP_JZ:   w_taken = i_szcy[1];
         OP_JC:   w_taken = i_szcy[0];
         OP_JS:   w_taken = i_szcy[2];
         default: w_taken = 1'b0;
      endcase
   end

   // One transfer per step. Anything not listed falls back to an idle
   // PC->PC cycle that also marks the instruction as finished.
   always_comb begin
      o_xsrc     = SRC_PC;
      o_xdst     = DST_PC;
      o_aluop    = ALU_PASS;
      o_rwe      = 1'b0;
      o_flgwe    = 1'b0;
      o_memWe    = 1'b0;
      o_lastStep = 1'b1;
      case (i_state)
         ST_F0: begin
            o_xsrc = SRC_PC; o_xdst = DST_MAR; o_rwe = 1'b1; o_lastStep = 1'b0;
         end
         ST_F1: begin
            o_xsrc = SRC_PC; o_xdst = DST_T; o_aluop = ALU_INC;
            o_rwe = 1'b1; o_lastStep = 1'b0;
         end
         ST_F2: begin
            o_xsrc = SRC_R; o_xdst = DST_PC; o_rwe = 1'b1; o_lastStep = 1'b0;
         end
         ST_F3: begin
            o_xsrc = SRC_RD; o_xdst = DST_I; o_rwe = 1'b1; o_lastStep = 1'b0;
         end
         ST_E0: begin
            o_rwe      = 1'b1;
            o_lastStep = 1'b0;
            if (w_op == OP_MOV) begin
               o_xsrc = w_rsBus; o_xdst = w_rdBus; o_lastStep = 1'b1;
            end else if (w_isImm) begin
               o_xsrc = SRC_PC; o_xdst = DST_MAR;
            end else if (w_op == OP_LD) begin
               o_xsrc = w_rsBus; o_xdst = DST_MAR;
            end else if (w_op == OP_ST) begin
               o_xsrc = w_rdBus; o_xdst = DST_MAR;
            end else if (w_isAlu) begin
               o_xsrc = w_rsBus; o_xdst = DST_T;
            end else begin
               o_rwe = 1'b0; o_lastStep = 1'b1;
            end
         end
         ST_E1: begin
            o_rwe      = 1'b1;
            o_lastStep = 1'b0;
            if (w_isImm) begin
               o_xsrc = SRC_PC; o_xdst = DST_T; o_aluop = ALU_INC;
            end else if (w_op == OP_LD) begin
               o_xsrc = SRC_RD; o_xdst = w_rdBus; o_lastStep = 1'b1;
            end else if (w_op == OP_ST) begin
               o_xsrc = w_rsBus; o_xdst = DST_WDR;
            end else if (w_isAlu) begin
               o_xsrc = w_rdBus; o_xdst = DST_T;
               o_aluop = aluForOp(w_op); o_flgwe = 1'b1;
            end else begin
               o_rwe = 1'b0; o_lastStep = 1'b1;
            end
         end
         ST_E2: begin
            o_rwe      = 1'b1;
            o_lastStep = 1'b1;
            if (w_isImm) begin
               o_xsrc = SRC_R; o_xdst = DST_PC; o_lastStep = 1'b0;
            end else if (w_op == OP_ST) begin
               o_rwe = 1'b0; o_memWe = 1'b1;
            end else if (w_isAlu) begin
               o_xsrc = SRC_R; o_xdst = w_rdBus;
            end else begin
               o_rwe = 1'b0;
            end
         end
         ST_E3: begin
            if (w_op == OP_LDI) begin
               o_xsrc = SRC_RD; o_xdst = w_rdBus; o_rwe = 1'b1;
            end else if (w_isImm && w_taken) begin
               o_xsrc = SRC_RD; o_xdst = DST_PC; o_rwe = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
// Microcoded sequencer for the CDEC 8-bit CPU: a 4-cycle fetch followed by
// an opcode-specific execute sequence, gated by run and stopped by HALT.
// Ports:
//   clock, reset   system clock (rising edge), async active-high reset
//   run            1 = advance, 0 = freeze state and issue idle cycles
//   I              instruction register
//   SZCy           flags {S,Z,Cy}
//   xsrc, xdst     Xbus transfer of the cycle
//   aluop          ALU operation
//   Rwe            1 = real transfer
//   FLGwe          load flags from the ALU
//   mem_we         memory write strobe
//   halted         1 while in HALT
//   dbg_state      current state encoding
// ---------------------------------------------------------------------------
module control_unit
   import cdec_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       run,
   input  logic [7:0] I,
   input  logic [2:0] SZCy,
   output logic [2:0] xsrc,
   output logic [2:0] xdst,
   output logic [3:0] aluop,
   output logic       Rwe,
   output logic       FLGwe,
   output logic       mem_we,
   output logic       halted,
   output logic [3:0] dbg_state
);

   state_t     r_state;
   state_t     w_nextState;
   logic [2:0] w_xsrc;
   logic [2:0] w_xdst;
   logic [3:0] w_aluop;
   logic       w_rwe;
   logic       w_flgwe;
   logic       w_memWe;
   logic       w_lastStep;
   logic       w_active;

   cdec_decode uDecode (
      .i_state    (r_state),
      .i_instr    (I),
      .i_szcy     (SZCy),
      .o_xsrc     (w_xsrc),
      .o_xdst     (w_xdst),
      .o_aluop    (w_aluop),
      .o_rwe      (w_rwe),
      .o_flgwe    (w_flgwe),
      .o_memWe    (w_memWe),
      .o_lastStep (w_lastStep)
   );

   // State register: only moves while run is high
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= ST_F0;
      end else if (run) begin
         r_state <= w_nextState;
      end
   end

   // Next step. After F3 the freshly loaded opcode picks the path; the
   // last execute step goes straight back to F0 with no bubble.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_F0: w_nextState = ST_F1;
         ST_F1: w_nextState = ST_F2;
         ST_F2: w_nextState = ST_F3;
         ST_F3: begin
            if (I[7:4] == OP_HALT) begin
               w_nextState = ST_HALT;
            end else if ((I[7:4] == OP_NOP) || (I[7:4] > OP_JS)) begin
               w_nextState = ST_F0;
            end else begin
               w_nextState = ST_E0;
            end
         end
         ST_E0:   w_nextState = w_lastStep ? ST_F0 : ST_E1;
         ST_E1:   w_nextState = w_lastStep ? ST_F0 : ST_E2;
         ST_E2:   w_nextState = w_lastStep ? ST_F0 : ST_E3;
         ST_E3:   w_nextState = ST_F0;
         ST_HALT: w_nextState = ST_HALT;
         default: w_nextState = ST_F0;
      endcase
   end

   // Any cycle that does not advance (run low, reset held, HALT) is an
   // idle PC->PC cycle with every strobe low.
   assign w_active = run && !reset && (r_state != ST_HALT);

   always_comb begin
      xsrc   = SRC_PC;
      xdst   = DST_PC;
      aluop  = ALU_PASS;
      Rwe    = 1'b0;
      FLGwe  = 1'b0;
      mem_we = 1'b0;
      if (w_active) begin
         xsrc   = w_xsrc;
         xdst   = w_xdst;
         aluop  = w_aluop;
         Rwe    = w_rwe;
         FLGwe  = w_flgwe;
         mem_we = w_memWe;
      end
   end

   assign halted    = (r_state == ST_HALT);
   assign dbg_state = r_state;

endmodule

// File: tb/tb_control_unit.sv
// ---------------------------------------------------------------------------
// tb_control_unit
// Directed bench for the CDEC control unit: walks fetch and several execute
// sequences, run gating, jumps taken/not taken, HALT and async reset.
// ---------------------------------------------------------------------------
module tb_control_unit;

   logic       clock;
   logic       reset;
   logic       run;
   logic [7:0] I;
   logic [2:0] SZCy;
   logic [2:0] xsrc;
   logic [2:0] xdst;
   logic [3:0] aluop;
   logic       Rwe;
   logic       FLGwe;
   logic       mem_we;
   logic       halted;
   logic [3:0] dbg_state;

   int total;
   int bad;

   control_unit dut (
      .clock     (clock),
      .reset     (reset),
      .run       (run),
      .I         (I),
      .SZCy      (SZCy),
      .xsrc      (xsrc),
      .xdst      (xdst),
      .aluop     (aluop),
      .Rwe       (Rwe),
      .FLGwe     (FLGwe),
      .mem_we    (mem_we),
      .halted    (halted),
      .dbg_state (dbg_state)
   );

   // 10-unit clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Single comparison point: counts and reports
   task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Checks the transfer of the current cycle
   task automatic checkBus(input string tag, input logic [2:0] s, input logic [2:0] d,
                           input logic rwe);
      checkOutput({tag, ".xsrc"}, {13'd0, xsrc}, {13'd0, s});
      checkOutput({tag, ".xdst"}, {13'd0, xdst}, {13'd0, d});
      checkOutput({tag, ".Rwe"},  {15'd0, Rwe},  {15'd0, rwe});
   endtask

   // Sets inputs then advances one clock, sampling 1 unit after the edge
   task automatic applyStimulus(input logic r, input logic [7:0] ins, input logic [2:0] f);
      run  = r;
      I    = ins;
      SZCy = f;
      @(posedge clock);
      #1;
   endtask

   // Walks the four fetch cycles for instruction ins, ending in the step after F3
   task automatic doFetch(input string tag, input logic [7:0] ins, input logic [2:0] f);
      run = 1'b1; I = ins; SZCy = f;
      #0;
      checkOutput({tag, ".F0.state"}, {12'd0, dbg_state}, 16'd0);
      checkBus({tag, ".F0"}, 3'd0, 3'd4, 1'b1);
      applyStimulus(1'b1, ins, f);
      checkBus({tag, ".F1"}, 3'd0, 3'd6, 1'b1);
      checkOutput({tag, ".F1.aluop"}, {12'd0, aluop}, 16'd1);
      checkOutput({tag, ".F1.FLGwe"}, {15'd0, FLGwe}, 16'd0);
      applyStimulus(1'b1, ins, f);
      checkBus({tag, ".F2"}, 3'd4, 3'd0, 1'b1);
      applyStimulus(1'b1, ins, f);
      checkBus({tag, ".F3"}, 3'd5, 3'd7, 1'b1);
      applyStimulus(1'b1, ins, f);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      run   = 1'b1;
      I     = 8'h00;
      SZCy  = 3'b000;
      @(posedge clock);
      @(posedge clock);
      #1;
      // Held in reset: state F0, nothing issued
      checkOutput("reset.state",  {12'd0, dbg_state}, 16'd0);
      checkOutput("reset.halted", {15'd0, halted},    16'd0);
      checkOutput("reset.Rwe",    {15'd0, Rwe},       16'd0);
      reset = 1'b0;

      // NOP: fetch only, then F0 again
      doFetch("nop", 8'h00, 3'b000);
      checkOutput("nop.back", {12'd0, dbg_state}, 16'd0);

      // ADD B,C
      doFetch("add", 8'h56, 3'b000);
      checkBus("add.E0", 3'd3, 3'd6, 1'b1);
      checkOutput("add.E0.FLGwe", {15'd0, FLGwe}, 16'd0);
      applyStimulus(1'b1, 8'h56, 3'b000);
      checkBus("add.E1", 3'd2, 3'd6, 1'b1);
      checkOutput("add.E1.aluop", {12'd0, aluop}, 16'd2);
      checkOutput("add.E1.FLGwe", {15'd0, FLGwe}, 16'd1);
      applyStimulus(1'b1, 8'h56, 3'b000);
      checkBus("add.E2", 3'd4, 3'd2, 1'b1);
      checkOutput("add.E2.FLGwe", {15'd0, FLGwe}, 16'd0);
      applyStimulus(1'b1, 8'h56, 3'b000);
      checkOutput("add.back", {12'd0, dbg_state}, 16'd0);

      // ADD B,C again with run dropped for 3 cycles at E1
      doFetch("addrun", 8'h56, 3'b000);
      applyStimulus(1'b1, 8'h56, 3'b000);
      checkOutput("addrun.E1.state", {12'd0, dbg_state}, 16'd5);
      run = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         checkOutput("addrun.hold.state", {12'd0, dbg_state}, 16'd5);
         checkOutput("addrun.hold.Rwe",   {15'd0, Rwe},       16'd0);
         checkOutput("addrun.hold.FLGwe", {15'd0, FLGwe},     16'd0);
         applyStimulus(1'b0, 8'h56, 3'b000);
      end
      run = 1'b1;
      #1;
      checkBus("addrun.E1", 3'd2, 3'd6, 1'b1);
      checkOutput("addrun.E1.FLGwe", {15'd0, FLGwe}, 16'd1);
      applyStimulus(1'b1, 8'h56, 3'b000);
      checkBus("addrun.E2", 3'd4, 3'd2, 1'b1);
      checkOutput("addrun.E2.FLGwe", {15'd0, FLGwe}, 16'd0);
      applyStimulus(1'b1, 8'h56, 3'b000);
      checkOutput("addrun.back", {12'd0, dbg_state}, 16'd0);

      // AND C,B: rd=C(3) rs=B(2)
      doFetch("and", 8'h79, 3'b000);
      checkBus("and.E0", 3'd2, 3'd6, 1'b1);
      applyStimulus(1'b1, 8'h79, 3'b000);
      checkOutput("and.E1.aluop", {12'd0, aluop}, 16'd4);
      checkBus("and.E1", 3'd3, 3'd6, 1'b1);
      applyStimulus(1'b1, 8'h79, 3'b000);
      checkBus("and.E2", 3'd4, 3'd3, 1'b1);
      applyStimulus(1'b1, 8'h79, 3'b000);

      // ST [B],C: rd=B rs=C
      doFetch("st", 8'h46, 3'b000);
      checkBus("st.E0", 3'd2, 3'd4, 1'b1);
      checkOutput("st.E0.memwe", {15'd0, mem_we}, 16'd0);
      applyStimulus(1'b1, 8'h46, 3'b000);
      checkBus("st.E1", 3'd3, 3'd5, 1'b1);
      applyStimulus(1'b1, 8'h46, 3'b000);
      checkBus("st.E2", 3'd0, 3'd0, 1'b0);
      checkOutput("st.E2.memwe", {15'd0, mem_we}, 16'd1);
      applyStimulus(1'b1, 8'h46, 3'b000);
      checkOutput("st.after.memwe", {15'd0, mem_we},    16'd0);
      checkOutput("st.back",        {12'd0, dbg_state}, 16'd0);

      // MOV C,PC: rs=PC(bus 0) -> rd=C(bus 3), single step
      doFetch("mov", 8'h1B, 3'b000);
      checkBus("mov.E0", 3'd0, 3'd3, 1'b1);
      applyStimulus(1'b1, 8'h1B, 3'b000);
      checkOutput("mov.back", {12'd0, dbg_state}, 16'd0);

      // JZ taken (Z=1)
      doFetch("jzt", 8'hB0, 3'b010);
      checkBus("jzt.E0", 3'd0, 3'd4, 1'b1);
      applyStimulus(1'b1, 8'hB0, 3'b010);
      checkBus("jzt.E1", 3'd0, 3'd6, 1'b1);
      checkOutput("jzt.E1.aluop", {12'd0, aluop}, 16'd1);
      checkOutput("jzt.E1.FLGwe", {15'd0, FLGwe}, 16'd0);
      applyStimulus(1'b1, 8'hB0, 3'b010);
      checkBus("jzt.E2", 3'd4, 3'd0, 1'b1);
      applyStimulus(1'b1, 8'hB0, 3'b010);
      checkBus("jzt.E3", 3'd5, 3'd0, 1'b1);
      applyStimulus(1'b1, 8'hB0, 3'b010);
      checkOutput("jzt.back", {12'd0, dbg_state}, 16'd0);

      // JZ not taken (Z=0, other flags set)
      doFetch("jzn", 8'hB0, 3'b101);
      applyStimulus(1'b1, 8'hB0, 3'b101);
      applyStimulus(1'b1, 8'hB0, 3'b101);
      applyStimulus(1'b1, 8'hB0, 3'b101);
      checkOutput("jzn.E3.state", {12'd0, dbg_state}, 16'd7);
      checkBus("jzn.E3", 3'd0, 3'd0, 1'b0);
      applyStimulus(1'b1, 8'hB0, 3'b101);
      checkOutput("jzn.back", {12'd0, dbg_state}, 16'd0);

      // Opcode 0xE behaves as NOP
      doFetch("undef", 8'hE5, 3'b000);
      checkOutput("undef.back", {12'd0, dbg_state}, 16'd0);

      // HALT, then async reset in the middle of a cycle
      doFetch("halt", 8'hF0, 3'b000);
      for (int k = 0; k < 3; k++) begin
         checkOutput("halt.state",  {12'd0, dbg_state}, 16'd8);
         checkOutput("halt.halted", {15'd0, halted},    16'd1);
         checkBus("halt.idle", 3'd0, 3'd0, 1'b0);
         applyStimulus(1'b1, 8'h00, 3'b000);
      end
      #2;
      reset = 1'b1;
      #1;
      checkOutput("areset.state",  {12'd0, dbg_state}, 16'd0);
      checkOutput("areset.halted", {15'd0, halted},    16'd0);
      checkOutput("areset.Rwe",    {15'd0, Rwe},       16'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      #1;
      checkBus("areset.F0", 3'd0, 3'd4, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Safety net against a hung run
   initial begin
      #20000;
      $display("[TB] FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] timeout");
   end

endmodule
